// File: rtl/ddr3_avl_tester.sv
// ddr3_avl_tester
//   Avalon-MM initiator that exercises the DDR3 EMIF local slave port.
//   It waits for EMIF calibration, writes an LFSR pattern over NUM_WORDS words,
//   reads them back with up to MAX_OUTSTANDING pipelined reads, and compares
//   each returned word. The 4-bit status word feeds the ddr3_status PIO.
//
// Ports
//   clk, reset_n          : afi_half_clk domain, async active-low reset
//   start, seed           : one-cycle start pulse, LFSR seed sampled with it
//   local_init_done,
//   local_cal_success,
//   local_cal_fail        : EMIF calibration status
//   avl_*                 : Avalon-MM initiator (single-word bursts)
//   status                : [0] cal_ok, [1] busy, [2] pass, [3] fail
//   err_count             : mismatching words, saturating
//   first_fail_addr       : word address of the first mismatch
//   timeout_flag          : pass aborted for lack of forward progress
module ddr3_avl_tester #(
    parameter int ADDR_W          = 26,
    parameter int DATA_W          = 64,
    parameter int NUM_WORDS       = 1024,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT         = 65535
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [31:0]         seed,
    input  logic                local_init_done,
    input  logic                local_cal_success,
    input  logic                local_cal_fail,
    output logic [ADDR_W-1:0]   avl_address,
    output logic                avl_read,
    output logic                avl_write,
    output logic [DATA_W-1:0]   avl_writedata,
    output logic [DATA_W/8-1:0] avl_byteenable,
    output logic [2:0]          avl_burstcount,
    input  logic                avl_waitrequest,
    input  logic [DATA_W-1:0]   avl_readdata,
    input  logic                avl_readdatavalid,
    output logic [3:0]          status,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_fail_addr,
    output logic                timeout_flag
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;
    localparam logic [CNT_W-1:0] WORDS     = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);
    localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] v);
        return {(DATA_W/64){v, ~v}};
    endfunction

    state_t            state;
    logic [31:0]       seed_q;
    logic [31:0]       wr_lfsr;
    logic [31:0]       exp_lfsr;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_issued;
    logic [CNT_W-1:0]  rd_rcvd;
    logic [OUT_W-1:0]  outstanding;
    logic [TO_W-1:0]   to_cnt;
    logic              cmp_valid;
    logic              cmp_mismatch;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cal_ok;
    logic              busy;
    logic              pass;
    logic              fail;

    logic              active;
    logic              wr_accept;
    logic              rd_accept;
    logic              rdv_live;
    logic              progress;
    logic              timed_out;
    logic              abort;
    logic [CNT_W-1:0]  issued_nxt;
    logic [OUT_W-1:0]  out_nxt;
    logic [31:0]       seed_eff;
    logic [31:0]       wr_lfsr_nxt;

    assign avl_byteenable = '1;
    assign avl_burstcount = 3'd1;
    assign status         = {fail, pass, busy, cal_ok};

    always_comb begin
        active      = (state == WAIT_CAL) || (state == WRITE) ||
                      (state == READ)     || (state == DRAIN);
        wr_accept   = avl_write & ~avl_waitrequest;
        rd_accept   = avl_read & ~avl_waitrequest;
        // read data outside READ/DRAIN belongs to an abandoned pass
        rdv_live    = avl_readdatavalid & ((state == READ) || (state == DRAIN));
        progress    = wr_accept | rd_accept | avl_readdatavalid;
        timed_out   = ~progress & (to_cnt == TO_LAST);
        abort       = active & (local_cal_fail | timed_out);
        issued_nxt  = rd_issued + CNT_W'(rd_accept);
        out_nxt     = outstanding + OUT_W'(rd_accept) - OUT_W'(rdv_live);
        seed_eff    = (seed == 32'd0) ? 32'd1 : seed;
        wr_lfsr_nxt = lfsr_next(wr_lfsr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            avl_address     <= '0;
            avl_read        <= 1'b0;
            avl_write       <= 1'b0;
            avl_writedata   <= '0;
            err_count       <= '0;
            first_fail_addr <= '0;
            timeout_flag    <= 1'b0;
            seed_q          <= 32'd1;
            wr_lfsr         <= 32'd1;
            exp_lfsr        <= 32'd1;
            wr_cnt          <= '0;
            rd_issued       <= '0;
            rd_rcvd         <= '0;
            outstanding     <= '0;
            to_cnt          <= '0;
            cmp_valid       <= 1'b0;
            cmp_mismatch    <= 1'b0;
            cmp_addr        <= '0;
            cal_ok          <= 1'b0;
            busy            <= 1'b0;
            pass            <= 1'b0;
            fail            <= 1'b0;
        end else begin
            cal_ok <= local_init_done & local_cal_success;

            // Compare stage 1: register the mismatch and its address.
            cmp_valid <= rdv_live;
            if (rdv_live) begin
                cmp_mismatch <= (avl_readdata != pattern(exp_lfsr));
                cmp_addr     <= rd_rcvd[ADDR_W-1:0];
                exp_lfsr     <= lfsr_next(exp_lfsr);
                rd_rcvd      <= rd_rcvd + 1'b1;
            end

            // Compare stage 2: accumulate into the result registers.
            if (cmp_valid && cmp_mismatch && active) begin
                if (err_count == '0)
                    first_fail_addr <= cmp_addr;
                if (err_count != '1)
                    err_count <= err_count + 16'd1;
            end

            to_cnt <= (active && !progress) ? to_cnt + 1'b1 : '0;

            if (abort) begin
                state        <= DONE;
                avl_read     <= 1'b0;
                avl_write    <= 1'b0;
                busy         <= 1'b0;
                pass         <= 1'b0;
                fail         <= 1'b1;
                timeout_flag <= ~local_cal_fail;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state           <= WAIT_CAL;
                            err_count       <= '0;
                            first_fail_addr <= '0;
                            timeout_flag    <= 1'b0;
                            pass            <= 1'b0;
                            fail            <= 1'b0;
                            busy            <= 1'b1;
                            seed_q          <= seed_eff;
                            wr_lfsr         <= seed_eff;
                        end
                    end

                    WAIT_CAL: begin
                        if (local_init_done && local_cal_success) begin
                            state         <= WRITE;
                            avl_write     <= 1'b1;
                            avl_address   <= '0;
                            avl_writedata <= pattern(wr_lfsr);
                            wr_cnt        <= '0;
                        end
                    end

                    WRITE: begin
                        if (wr_accept) begin
                            wr_lfsr       <= wr_lfsr_nxt;
                            avl_writedata <= pattern(wr_lfsr_nxt);
                            avl_address   <= avl_address + 1'b1;
                            wr_cnt        <= wr_cnt + 1'b1;
                            if (wr_cnt == LAST_IDX) begin
                                state       <= READ;
                                avl_write   <= 1'b0;
                                avl_read    <= 1'b1;
                                avl_address <= '0;
                                exp_lfsr    <= seed_q;
                                rd_issued   <= '0;
                                rd_rcvd     <= '0;
                                outstanding <= '0;
                            end
                        end
                    end

                    READ: begin
                        rd_issued   <= issued_nxt;
                        outstanding <= out_nxt;
                        if (rd_accept)
                            avl_address <= avl_address + 1'b1;
                        // avl_read only falls after an accept, so a stalled
                        // request is always held.
                        if (issued_nxt == WORDS) begin
                            state    <= DRAIN;
                            avl_read <= 1'b0;
                        end else begin
                            avl_read <= (out_nxt < MAX_OUT);
                        end
                    end

                    DRAIN: begin
                        outstanding <= out_nxt;
                        // Wait one more cycle so the last compare has landed.
                        if (rd_rcvd == WORDS && !cmp_valid) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            pass  <= (err_count == '0);
                            fail  <= (err_count != '0);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr3_avl_tester.sv
module tb_ddr3_avl_tester;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed_r = 32'd0;
    logic        init_done = 1'b1;
    logic        cal_success = 1'b1;
    logic        cal_fail = 1'b0;

    // main DUT (16 words)
    logic [7:0]  avl_address;
    logic        avl_read, avl_write;
    logic [63:0] avl_writedata;
    logic [7:0]  avl_byteenable;
    logic [2:0]  avl_burstcount;
    logic        wreq = 1'b0;
    logic [63:0] rdata = '0;
    logic        rdv = 1'b0;
    logic [3:0]  status;
    logic [15:0] err_count;
    logic [7:0]  first_fail_addr;
    logic        timeout_flag;

    // single-word DUT
    logic [7:0]  address_1w;
    logic        read_1w, write_1w;
    logic [63:0] writedata_1w;
    logic [7:0]  byteenable_1w;
    logic [2:0]  burstcount_1w;
    logic        wreq_1w = 1'b0;
    logic [63:0] rdata_1w = '0;
    logic        rdv_1w = 1'b0;
    logic [3:0]  status_1w;
    logic [15:0] err_count_1w;
    logic [7:0]  ffa_1w;
    logic        timeout_1w;

    always #5 clk = ~clk;

    ddr3_avl_tester #(.ADDR_W(8), .DATA_W(64), .NUM_WORDS(16),
                      .MAX_OUTSTANDING(8), .TIMEOUT(100)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed_r),
        .local_init_done(init_done), .local_cal_success(cal_success),
        .local_cal_fail(cal_fail),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
        .avl_burstcount(avl_burstcount), .avl_waitrequest(wreq),
        .avl_readdata(rdata), .avl_readdatavalid(rdv),
        .status(status), .err_count(err_count),
        .first_fail_addr(first_fail_addr), .timeout_flag(timeout_flag)
    );

    ddr3_avl_tester #(.ADDR_W(8), .DATA_W(64), .NUM_WORDS(1),
                      .MAX_OUTSTANDING(8), .TIMEOUT(100)) u_one (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed_r),
        .local_init_done(init_done), .local_cal_success(cal_success),
        .local_cal_fail(cal_fail),
        .avl_address(address_1w), .avl_read(read_1w), .avl_write(write_1w),
        .avl_writedata(writedata_1w), .avl_byteenable(byteenable_1w),
        .avl_burstcount(burstcount_1w), .avl_waitrequest(wreq_1w),
        .avl_readdata(rdata_1w), .avl_readdatavalid(rdv_1w),
        .status(status_1w), .err_count(err_count_1w),
        .first_fail_addr(ffa_1w), .timeout_flag(timeout_1w)
    );

    // ---------------- slave models ----------------
    logic [63:0] mem [0:255];
    logic [63:0] pend_data[$];
    int unsigned pend_due[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          wait_rand = 1'b0;
    bit          corrupt_en = 1'b0;
    int unsigned stop_after = 32'hFFFF_FFFF;
    int unsigned returned = 0;
    int unsigned wr_seen = 0, rd_seen = 0;
    int unsigned last_prog = 0;
    int          inflight = 0, max_inflight = 0;
    int unsigned stall_viol = 0;
    bit          stalled = 1'b0;
    logic        st_rd, st_wr;
    logic [7:0]  st_addr;
    logic [63:0] st_wd;

    logic [63:0] mem_1w = '0;
    int unsigned wr_1w = 0, rd_1w = 0;
    bit          ret_1w = 1'b0;

    // Bookkeeping on the active edge sees the values the DUT is sampling.
    always @(posedge clk) begin
        logic [63:0] d;
        cyc++;
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled && (avl_read !== st_rd || avl_write !== st_wr ||
                            avl_address !== st_addr || avl_writedata !== st_wd))
                stall_viol++;
            stalled = (avl_read | avl_write) && wreq;
            st_rd = avl_read; st_wr = avl_write;
            st_addr = avl_address; st_wd = avl_writedata;
            if (avl_write && !wreq) begin
                mem[avl_address] = avl_writedata;
                wr_seen++;
                last_prog = cyc;
            end
            if (avl_read && !wreq) begin
                d = mem[avl_address];
                if (corrupt_en && avl_address == 8'd3) d[5] = ~d[5];
                if (corrupt_en && avl_address == 8'd9) d[0] = ~d[0];
                pend_data.push_back(d);
                pend_due.push_back(cyc + lat);
                rd_seen++;
                inflight++;
                last_prog = cyc;
            end
            if (rdv) begin
                inflight--;
                last_prog = cyc;
            end
            if (inflight > max_inflight) max_inflight = inflight;

            if (write_1w) begin mem_1w = writedata_1w; wr_1w++; end
            ret_1w = read_1w;
            if (read_1w) rd_1w++;
        end
    end

    always @(negedge clk) begin
        wreq = wait_rand && ($urandom_range(0, 1) == 1);
        rdv = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc && returned < stop_after) begin
            rdv = 1'b1;
            rdata = pend_data.pop_front();
            void'(pend_due.pop_front());
            returned++;
        end
        rdv_1w = ret_1w;
        rdata_1w = mem_1w;
        ret_1w = 1'b0;
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input logic [31:0] s, input int k);
        logic [31:0] x;
        x = (s == 32'd0) ? 32'd1 : s;
        for (int i = 0; i < k; i++)
            x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return {x, ~x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_pass(input logic [31:0] s);
        seed_r = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && status[1]; i++) tick();
        check(tag, {63'd0, status[1]}, 64'd0);
    endtask

    task automatic clear_counts();
        wr_seen = 0; rd_seen = 0; returned = 0;
        inflight = 0; max_inflight = 0; stall_viol = 0;
        wr_1w = 0; rd_1w = 0;
    endtask

    initial begin
        int unsigned fail_cyc;

        // reset state
        tick(); tick();
        check("rst_status", {60'd0, status}, 64'd0);
        check("rst_rw", {62'd0, avl_read, avl_write}, 64'd0);
        check("rst_addr", {56'd0, avl_address}, 64'd0);
        check("rst_wdata", avl_writedata, 64'd0);
        check("rst_err", {48'd0, err_count}, 64'd0);
        check("rst_timeout", {63'd0, timeout_flag}, 64'd0);
        check("byteenable", {56'd0, avl_byteenable}, 64'hFF);
        check("burstcount", {61'd0, avl_burstcount}, 64'd1);
        reset_n = 1'b1;
        tick(); tick();
        check("cal_ok_idle", {60'd0, status}, 64'h1);

        // ideal slave, seed ACE1
        clear_counts();
        start_pass(32'h0000_ACE1);
        check("busy_after_start", {60'd0, status}, 64'h3);
        wait_done("t1_done", 2000);
        check("t1_status", {60'd0, status}, 64'h5);
        check("t1_err", {48'd0, err_count}, 64'd0);
        check("t1_writes", 64'(wr_seen), 64'd16);
        check("t1_reads", 64'(rd_seen), 64'd16);
        check("t1_word0", mem[0], 64'h0000ACE1_FFFF531E);
        check("t1_word1", mem[1], 64'h80205673_7FDFA98C);
        check("t1_word15", mem[15], model_word(32'h0000_ACE1, 15));
        check("one_status", {60'd0, status_1w}, 64'h5);
        check("one_writes", 64'(wr_1w), 64'd1);
        check("one_reads", 64'(rd_1w), 64'd1);
        check("one_word", mem_1w, 64'h0000ACE1_FFFF531E);

        // random waitrequest, 20-cycle read latency
        clear_counts();
        wait_rand = 1'b1; lat = 20;
        start_pass(32'h1234_5678);
        wait_done("t2_done", 4000);
        check("t2_status", {60'd0, status}, 64'h5);
        check("t2_stall_stable", 64'(stall_viol), 64'd0);
        check("t2_inflight_le8", {63'd0, max_inflight <= 8}, 64'd1);
        check("t2_inflight_used", {63'd0, max_inflight > 1}, 64'd1);
        check("t2_reads", 64'(rd_seen), 64'd16);
        check("t2_word7", mem[7], model_word(32'h1234_5678, 7));
        wait_rand = 1'b0; lat = 1;
        tick();

        // corrupted reads at addresses 3 and 9
        clear_counts();
        corrupt_en = 1'b1;
        start_pass(32'h0000_ACE1);
        wait_done("t3_done", 2000);
        check("t3_err", {48'd0, err_count}, 64'd2);
        check("t3_ffa", {56'd0, first_fail_addr}, 64'd3);
        check("t3_status", {60'd0, status}, 64'h9);
        check("t3_timeout", {63'd0, timeout_flag}, 64'd0);
        corrupt_en = 1'b0;

        // calibration failure while waiting
        clear_counts();
        cal_success = 1'b0;
        tick();
        start_pass(32'h0000_0042);
        for (int i = 0; i < 10; i++) tick();
        check("t4_waiting", {60'd0, status}, 64'h2);
        cal_fail = 1'b1;
        tick();
        cal_fail = 1'b0;
        check("t4_status", {60'd0, status}, 64'h8);
        check("t4_no_cmds", 64'(wr_seen + rd_seen), 64'd0);
        check("t4_timeout", {63'd0, timeout_flag}, 64'd0);
        cal_success = 1'b1;
        tick();

        // slave stops answering after 5 reads
        clear_counts();
        stop_after = 5;
        start_pass(32'h0000_BEEF);
        fail_cyc = 0;
        for (int i = 0; i < 600 && !status[3]; i++) tick();
        fail_cyc = cyc;
        check("t5_fail_seen", {63'd0, status[3]}, 64'd1);
        check("t5_idle_cycles", 64'(fail_cyc - last_prog), 64'd100);
        check("t5_timeout", {63'd0, timeout_flag}, 64'd1);
        check("t5_status", {60'd0, status}, 64'h9);
        check("t5_returned", 64'(returned), 64'd5);
        pend_data.delete();
        pend_due.delete();
        stop_after = 32'hFFFF_FFFF;
        tick();

        // reset in the middle of the write phase, then seed 0
        clear_counts();
        start_pass(32'h0000_0005);
        for (int i = 0; i < 200 && wr_seen < 5; i++) tick();
        check("t6_mid_write", {63'd0, avl_write}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_write", {63'd0, avl_write}, 64'd0);
        check("t6_rst_status", {60'd0, status}, 64'd0);
        check("t6_rst_addr", {56'd0, avl_address}, 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        clear_counts();
        start_pass(32'h0000_0000);
        wait_done("t6_done", 2000);
        check("t6_status", {60'd0, status}, 64'h5);
        check("t6_word0", mem[0], 64'h00000001_FFFFFFFE);
        check("t6_word1", mem[1], 64'h80200003_7FDFFFFC);
        check("t6_writes", 64'(wr_seen), 64'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
